// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Purpose  : Multicycle MIPS-subset control FSM with a unified, stallable memory.
// Revision : 1.0  initial release
// ============================================================================
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       memread,
  output logic       we,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    BEQ_EX   = 4'd8,
    ADDI_EX  = 4'd9,
    ADDI_WB  = 4'd10,
    JUMP_EX  = 4'd11
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;

  state_t r_state;
  state_t w_next_state;
  logic   r_illegal_op;
  logic   w_illegal_op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= FETCH;
      r_illegal_op <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_illegal_op <= w_illegal_op;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_illegal_op = 1'b0;
    IorD         = 1'b0;
    memread      = 1'b0;
    we           = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    Branch       = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    PCSource     = 2'b00;
    // Outputs stay at 0 for as long as reset is held, even though state reads FETCH.
    if (rst) begin
      case (r_state)
        FETCH: begin
          memread = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          if (mem_ready) w_next_state = DECODE;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          case (opcode)
            C_OP_RTYPE:       w_next_state = RTYPE_EX;
            C_OP_LW, C_OP_SW: w_next_state = MEMADR;
            C_OP_BEQ:         w_next_state = BEQ_EX;
            C_OP_ADDI:        w_next_state = ADDI_EX;
            C_OP_J:           w_next_state = JUMP_EX;
            default: begin
              w_next_state = FETCH;
              w_illegal_op = 1'b1;
            end
          endcase
        end
        MEMADR: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = 2'b10;
          w_next_state = (opcode == C_OP_LW) ? MEMRD : MEMWR;
        end
        MEMRD: begin
          memread = 1'b1;
          IorD    = 1'b1;
          if (mem_ready) w_next_state = MEMWB;
        end
        MEMWB: begin
          MemtoReg     = 1'b1;
          RegWrite     = 1'b1;
          w_next_state = FETCH;
        end
        MEMWR: begin
          // The strobe fires only in the cycle the memory accepts it, so one pulse per store.
          IorD = 1'b1;
          we   = mem_ready;
          if (mem_ready) w_next_state = FETCH;
        end
        RTYPE_EX: begin
          ALUSrcA      = 1'b1;
          ALUOp        = 2'b10;
          w_next_state = RTYPE_WB;
        end
        RTYPE_WB: begin
          RegDst       = 1'b1;
          RegWrite     = 1'b1;
          w_next_state = FETCH;
        end
        BEQ_EX: begin
          ALUSrcA      = 1'b1;
          ALUOp        = 2'b01;
          PCSource     = 2'b01;
          Branch       = 1'b1;
          w_next_state = FETCH;
        end
        ADDI_EX: begin
          ALUSrcA      = 1'b1;
          ALUSrcB      = 2'b10;
          w_next_state = ADDI_WB;
        end
        ADDI_WB: begin
          RegWrite     = 1'b1;
          w_next_state = FETCH;
        end
        JUMP_EX: begin
          PCSource     = 2'b10;
          PCWrite      = 1'b1;
          w_next_state = FETCH;
        end
        default: w_next_state = FETCH;
      endcase
    end
  end

  assign state      = r_state;
  assign illegal_op = r_illegal_op;

endmodule
`default_nettype wire
